// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle o_wr per good byte.
// Optional UART_RX_FRAME_ERR_EN adds o_frame_err, a one-cycle pulse on a bad stop bit.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_data,
    output logic                 o_wr,
`ifdef UART_RX_FRAME_ERR_EN
    output logic                 o_frame_err,
`endif
    output logic [DATA_BITS-1:0] o_data
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 wr_q, wr_d;
    logic                 rx_meta_q, rx_s_q;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 ferr_q, ferr_d;
`endif

    // Synchroniser resets high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx_data;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end
    assign o_frame_err = ferr_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        wr_d    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Half-bit wait puts every later sample near bit centre.
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        idx_d   = '0;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        wr_d    = 1'b1;
                        state_d = StIdle;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_d  = 1'b1;
`endif
                        state_d = StWaitIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                // A low line after a bad stop bit must not be taken as a start bit.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign o_wr   = wr_q;
    assign o_data = data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a short bit period; table of frames plus corner sequences.
module tb_uart_rx_core;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       i_rx_data;
    logic       o_wr;
    logic [7:0] o_data;
`ifdef UART_RX_FRAME_ERR_EN
    logic       o_frame_err;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_data  (i_rx_data),
        .o_wr       (o_wr),
`ifdef UART_RX_FRAME_ERR_EN
        .o_frame_err(o_frame_err),
`endif
        .o_data     (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         wr_count   = 0;
    int         ferr_count = 0;
    int         dbl_cnt    = 0;
    int         unstable   = 0;
    logic       wr_prev    = 1'b0;
    logic       rst_prev   = 1'b0;
    logic [7:0] data_prev  = 8'h00;
    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wr) begin
                wr_count++;
                pulse_cyc.push_back(cyc);
                pulse_data.push_back(o_data);
            end
            if (o_wr && wr_prev) dbl_cnt++;
            if (!o_wr && rst_prev && o_data !== data_prev) unstable++;
`ifdef UART_RX_FRAME_ERR_EN
            if (o_frame_err) ferr_count++;
`endif
        end
        wr_prev   = o_wr;
        data_prev = o_data;
        rst_prev  = rst_n;
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle_bits(input int n);
        i_rx_data = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx_data = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_wr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w0, f0, c0;
        vecs[0] = '{8'hE3, 1'b1, 8'hE3, 1, 0};
        vecs[1] = '{8'hED, 1'b0, 8'hE3, 0, 1};
        vecs[2] = '{8'hC7, 1'b1, 8'hC7, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b0, 8'h00, 0, 1};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

        rst_n     = 1'b0;
        i_rx_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_o_wr", {31'd0, o_wr}, 32'd0);
        check("reset_o_data", {24'd0, o_data}, 32'h00);
        rst_n = 1'b1;
        idle_bits(20);
        check("post_reset_no_wr", wr_count, 0);

        for (int v = 0; v < 6; v++) begin
            w0 = wr_count;
            f0 = ferr_count;
            send_frame(vecs[v].d, vecs[v].stop);
            idle_bits(3);
            check($sformatf("vec%0d_wr", v), wr_count - w0, vecs[v].exp_wr);
            check($sformatf("vec%0d_data", v), {24'd0, o_data}, {24'd0, vecs[v].exp_data});
`ifdef UART_RX_FRAME_ERR_EN
            check($sformatf("vec%0d_ferr", v), ferr_count - f0, vecs[v].exp_ferr);
`endif
        end

        // Back-to-back frames, also measures start-edge to strobe latency.
        pulse_cyc.delete();
        pulse_data.delete();
        c0 = cyc;
        send_frame(8'hE3, 1'b1);
        send_frame(8'hC7, 1'b1);
        idle_bits(3);
        check("b2b_pulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) begin
            check("b2b_first", {24'd0, pulse_data[0]}, 32'hE3);
            check("b2b_second", {24'd0, pulse_data[1]}, 32'hC7);
            check("b2b_spacing", pulse_cyc[1] - pulse_cyc[0], 10 * CPB);
            check("latency_range", {31'd0,
                  (pulse_cyc[0] - c0 >= (19 * CPB) / 2) &&
                  (pulse_cyc[0] - c0 <= (19 * CPB) / 2 + 8)}, 32'd1);
        end

        // Glitch shorter than half a bit, then a good frame.
        w0 = wr_count;
        i_rx_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle_bits(3);
        check("glitch_no_wr", wr_count - w0, 0);
        check("glitch_data_kept", {24'd0, o_data}, 32'hC7);
        send_frame(8'h55, 1'b1);
        idle_bits(3);
        check("after_glitch_wr", wr_count - w0, 1);
        check("after_glitch_data", {24'd0, o_data}, 32'h55);

        // Good frame followed by a line stuck low: one strobe only.
        w0 = wr_count;
        f0 = ferr_count;
        send_frame(8'h3C, 1'b1);
        i_rx_data = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        #1;
        idle_bits(3);
        check("stuck_low_wr", wr_count - w0, 1);
        check("stuck_low_data", {24'd0, o_data}, 32'h3C);
`ifdef UART_RX_FRAME_ERR_EN
        check("stuck_low_ferr", ferr_count - f0, 1);
`endif

        // Reset during data bit 4.
        w0 = wr_count;
        i_rx_data = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            i_rx_data = (8'hA5 >> i) & 8'h01;
            repeat (CPB) @(posedge clk);
        end
        i_rx_data = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_o_wr", {31'd0, o_wr}, 32'd0);
        check("midrst_o_data", {24'd0, o_data}, 32'h00);
        rst_n = 1'b1;
        idle_bits(3);
        check("midrst_no_wr", wr_count - w0, 0);
        check("midrst_data_zero", {24'd0, o_data}, 32'h00);
        send_frame(8'hA5, 1'b1);
        idle_bits(3);
        check("after_rst_wr", wr_count - w0, 1);
        check("after_rst_data", {24'd0, o_data}, 32'hA5);

        check("single_cycle_wr", dbl_cnt, 0);
        check("data_stable", unstable, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
